// File: rtl/halfduplex_xcvr_ctrl.sv
// Half-duplex transceiver direction control with switch guards,
// transmit tail and optional per-channel echo checking.
module halfduplex_xcvr_ctrl #(
  parameter int NumChannels             = 1,
  parameter int TransceiverSwitchCycles = 5,
  parameter int TransmitEndCycles       = 5,
  parameter bit EchoCheck               = 1'b0,
  parameter int EchoDelay               = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumChannels-1:0] tx_enable_i,
  input  logic [NumChannels-1:0] rx_enable_i,
  input  logic [NumChannels-1:0] tx_i,
  output logic [NumChannels-1:0] tx_ready_o,
  output logic [NumChannels-1:0] rx_o,
  output logic [NumChannels-1:0] busy_o,
  output logic [NumChannels-1:0] echo_err_o,
  output logic [NumChannels-1:0] di_o,
  output logic [NumChannels-1:0] de_o,
  output logic [NumChannels-1:0] ren_o,
  input  logic [NumChannels-1:0] ro_i
);

  localparam int MaxCyc =
    (TransceiverSwitchCycles > TransmitEndCycles) ?
    TransceiverSwitchCycles : TransmitEndCycles;
  localparam int CntW = $clog2(MaxCyc + 1);
  localparam logic [CntW-1:0] SwLoad =
    CntW'(TransceiverSwitchCycles - 1);
  localparam logic [CntW-1:0] EndLoad =
    CntW'(TransmitEndCycles - 1);

  typedef enum logic [2:0] {
    ST_RX,
    ST_SW_TX,
    ST_TX,
    ST_TX_END,
    ST_SW_RX
  } state_e;

  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            tx_en;
    logic            cnt_zero;
    logic            is_rx;
    logic            is_tx;
    logic            drv;
    logic            rx_en;
    logic            di;

    assign tx_en    = tx_enable_i[g];
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= ST_RX;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          ST_RX: begin
            if (tx_en) begin
              state_q <= ST_SW_TX;
              cnt_q   <= SwLoad;
            end
          end
          ST_SW_TX: begin
            if (!tx_en) begin
              state_q <= ST_SW_RX;
              cnt_q   <= SwLoad;
            end else if (cnt_zero) begin
              state_q <= ST_TX;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_TX: begin
            if (!tx_en) begin
              state_q <= ST_TX_END;
              cnt_q   <= EndLoad;
            end
          end
          ST_TX_END: begin
            if (tx_en) begin
              state_q <= ST_TX;
            end else if (cnt_zero) begin
              state_q <= ST_SW_RX;
              cnt_q   <= SwLoad;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_SW_RX: begin
            if (tx_en) begin
              state_q <= ST_SW_TX;
              cnt_q   <= SwLoad;
            end else if (cnt_zero) begin
              state_q <= ST_RX;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= ST_RX;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign is_rx = (state_q == ST_RX);
    assign is_tx = (state_q == ST_TX);
    assign drv   = (state_q == ST_SW_TX) || is_tx ||
                   (state_q == ST_TX_END);
    // Receive request reads as idle while reset is held.
    assign rx_en = rx_enable_i[g] & rst_ni;
    assign di    = is_tx ? tx_i[g] : 1'b1;

    assign de_o[g]       = drv;
    assign ren_o[g]      = drv ? ~EchoCheck : ~rx_en;
    assign di_o[g]       = di;
    assign rx_o[g]       = (is_rx && rx_en) ? ro_i[g] : 1'b1;
    assign busy_o[g]     = ~is_rx;
    assign tx_ready_o[g] = is_tx;

    if (EchoCheck) begin : g_echo
      localparam int VldW = $clog2(EchoDelay + 1);
      localparam logic [VldW-1:0] VldFull = VldW'(EchoDelay);

      logic [EchoDelay-1:0] sr_q;
      logic [VldW-1:0]      vld_q;
      logic                 err_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          sr_q  <= '1;
          vld_q <= '0;
          err_q <= 1'b0;
        end else begin
          sr_q[0] <= di;
          for (int i = 1; i < EchoDelay; i++) begin
            sr_q[i] <= sr_q[i-1];
          end
          if (!is_tx) begin
            vld_q <= '0;
          end else if (vld_q != VldFull) begin
            vld_q <= vld_q + 1'b1;
          end
          err_q <= is_tx && (vld_q == VldFull) &&
                   (ro_i[g] != sr_q[EchoDelay-1]);
        end
      end

      assign echo_err_o[g] = err_q;
    end else begin : g_no_echo
      assign echo_err_o[g] = 1'b0;
    end
  end

endmodule

// File: tb/tb_halfduplex_xcvr_ctrl.sv
// Self-checking bench for halfduplex_xcvr_ctrl: directed timing
// scenarios plus randomized traffic against a timestamp model.
module tb_halfduplex_xcvr_ctrl;

  localparam int S = 5;
  localparam int E = 5;

  localparam int M_RX   = 0;
  localparam int M_UP   = 1;
  localparam int M_TX   = 2;
  localparam int M_TAIL = 3;
  localparam int M_DN   = 4;

  logic clk;
  logic rst_n;

  logic [2:0] tx_en;
  logic [2:0] rx_en;
  logic [2:0] tx_d;
  logic [2:0] ro;
  logic [2:0] tx_ready;
  logic [2:0] rx_d;
  logic [2:0] busy;
  logic [2:0] echo_err;
  logic [2:0] di;
  logic [2:0] de;
  logic [2:0] ren;

  logic tx_en_e;
  logic rx_en_e;
  logic tx_d_e;
  logic ro_e;
  logic ready_e;
  logic rx_e;
  logic busy_e;
  logic err_e;
  logic di_e;
  logic de_e;
  logic ren_e;

  int n_tests;
  int n_fail;

  int cyc;
  int m_mode[3];
  int m_dl[3];

  halfduplex_xcvr_ctrl #(
    .NumChannels(3),
    .TransceiverSwitchCycles(S),
    .TransmitEndCycles(E),
    .EchoCheck(1'b0),
    .EchoDelay(2)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .tx_enable_i(tx_en),
    .rx_enable_i(rx_en),
    .tx_i(tx_d),
    .tx_ready_o(tx_ready),
    .rx_o(rx_d),
    .busy_o(busy),
    .echo_err_o(echo_err),
    .di_o(di),
    .de_o(de),
    .ren_o(ren),
    .ro_i(ro)
  );

  halfduplex_xcvr_ctrl #(
    .NumChannels(1),
    .TransceiverSwitchCycles(S),
    .TransmitEndCycles(E),
    .EchoCheck(1'b1),
    .EchoDelay(2)
  ) dut_e (
    .clk_i(clk),
    .rst_ni(rst_n),
    .tx_enable_i(tx_en_e),
    .rx_enable_i(rx_en_e),
    .tx_i(tx_d_e),
    .tx_ready_o(ready_e),
    .rx_o(rx_e),
    .busy_o(busy_e),
    .echo_err_o(err_e),
    .di_o(di_e),
    .de_o(de_e),
    .ren_o(ren_e),
    .ro_i(ro_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Deadlines are absolute edge numbers at which a guard expires.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int c = 0; c < 3; c++) begin
        m_mode[c] <= M_RX;
        m_dl[c]   <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int c = 0; c < 3; c++) begin
        case (m_mode[c])
          M_RX: if (tx_en[c]) begin
            m_mode[c] <= M_UP;
            m_dl[c]   <= cyc + S;
          end
          M_UP: if (!tx_en[c]) begin
            m_mode[c] <= M_DN;
            m_dl[c]   <= cyc + S;
          end else if (cyc >= m_dl[c]) begin
            m_mode[c] <= M_TX;
          end
          M_TX: if (!tx_en[c]) begin
            m_mode[c] <= M_TAIL;
            m_dl[c]   <= cyc + E;
          end
          M_TAIL: if (tx_en[c]) begin
            m_mode[c] <= M_TX;
          end else if (cyc >= m_dl[c]) begin
            m_mode[c] <= M_DN;
            m_dl[c]   <= cyc + S;
          end
          M_DN: if (tx_en[c]) begin
            m_mode[c] <= M_UP;
            m_dl[c]   <= cyc + S;
          end else if (cyc >= m_dl[c]) begin
            m_mode[c] <= M_RX;
          end
          default: m_mode[c] <= M_RX;
        endcase
      end
    end
  end

  task automatic test_reset();
    logic [6:0] got;
    rst_n   = 1'b0;
    tx_en   = '0;
    rx_en   = 3'b111;
    tx_d    = '0;
    ro      = '0;
    tx_en_e = 1'b0;
    rx_en_e = 1'b1;
    tx_d_e  = 1'b0;
    ro_e    = 1'b0;
    #2;
    n_tests++;
    if (de !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_de got %b exp 000", de);
    end
    n_tests++;
    if (ren !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_ren got %b exp 111", ren);
    end
    n_tests++;
    if (di !== 3'b111 || rx_d !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_data di %b rx %b exp 111", di, rx_d);
    end
    n_tests++;
    if (busy !== 3'b000 || tx_ready !== 3'b000 ||
        echo_err !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status busy %b rdy %b err %b exp 0",
               busy, tx_ready, echo_err);
    end
    got = {de_e, ren_e, di_e, rx_e, busy_e, ready_e, err_e};
    n_tests++;
    if (got !== 7'b0111000) begin
      n_fail++;
      $display("FAIL reset_echo_ch got %b exp 0111000", got);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (rx_d !== 3'b000 || ren !== 3'b000 || busy !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release rx %b ren %b busy %b exp 0",
               rx_d, ren, busy);
    end
  endtask

  task automatic test_single_tx();
    logic [4:0] got;
    logic [4:0] exp;
    tx_en = '0;
    rx_en = 3'b111;
    repeat (3) @(posedge clk);
    #1 tx_en[0] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      tx_en[0] = (c <= 19);
      ro[0]    = 1'($urandom);
      @(negedge clk);
      exp = {c <= 25, c >= 6 && c <= 20, c <= 30, c <= 25,
             (c <= 30) ? 1'b1 : ro[0]};
      got = {de[0], tx_ready[0], busy[0], ren[0], rx_d[0]};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL single_tx cyc %0d got %b exp %b",
                 c, got, exp);
      end
    end
  endtask

  task automatic test_resume();
    logic [4:0] got;
    logic [4:0] exp;
    logic       rdy;
    tx_en = '0;
    repeat (3) @(posedge clk);
    #1 tx_en[0] = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk);
      #1;
      tx_en[0] = (c <= 9) || (c >= 12 && c <= 14);
      ro[0]    = 1'($urandom);
      @(negedge clk);
      rdy = (c >= 6 && c <= 10) || (c >= 13 && c <= 15);
      exp = {c <= 20, rdy, c <= 25, c <= 20,
             (c <= 25) ? 1'b1 : ro[0]};
      got = {de[0], tx_ready[0], busy[0], ren[0], rx_d[0]};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL resume cyc %0d got %b exp %b",
                 c, got, exp);
      end
    end
  endtask

  task automatic test_abort();
    logic [4:0] got;
    logic [4:0] exp;
    tx_en = '0;
    repeat (3) @(posedge clk);
    #1 tx_en[0] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      tx_en[0] = (c <= 1);
      ro[0]    = 1'($urandom);
      @(negedge clk);
      exp = {c <= 2, 1'b0, c <= 7, c <= 2,
             (c <= 7) ? 1'b1 : ro[0]};
      got = {de[0], tx_ready[0], busy[0], ren[0], rx_d[0]};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL abort cyc %0d got %b exp %b",
                 c, got, exp);
      end
    end
  endtask

  task automatic test_echo();
    logic       dh[0:63];
    logic [5:0] got;
    logic [5:0] exp;
    tx_en_e = 1'b0;
    rx_en_e = 1'b1;
    repeat (3) @(posedge clk);
    #1 tx_en_e = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk);
      #1;
      tx_en_e = (c <= 29);
      tx_d_e  = 1'($urandom);
      ro_e    = ((c >= 3) ? dh[c-2] : 1'b1) ^ (c == 7 || c == 15);
      @(negedge clk);
      dh[c] = di_e;
      exp = {c == 16, 1'b0, c <= 35, c <= 40,
             c >= 6 && c <= 30, (c <= 40) ? 1'b1 : ro_e};
      got = {err_e, ren_e, de_e, busy_e, ready_e, rx_e};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL echo cyc %0d got %b exp %b", c, got, exp);
      end
    end
  endtask

  task automatic test_multi_random();
    logic [6:0] got;
    logic [6:0] exp;
    logic       drv;
    int         md;
    tx_en = '0;
    rx_en = 3'b111;
    repeat (12) @(posedge clk);
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      for (int ch = 0; ch < 3; ch++) begin
        if ($urandom_range(7) == 0) tx_en[ch] = ~tx_en[ch];
        if ($urandom_range(15) == 0) rx_en[ch] = ~rx_en[ch];
      end
      tx_d = 3'($urandom);
      ro   = 3'($urandom);
      @(negedge clk);
      for (int ch = 0; ch < 3; ch++) begin
        md  = m_mode[ch];
        drv = (md == M_UP) || (md == M_TX) || (md == M_TAIL);
        exp = {drv, md == M_TX, md != M_RX,
               drv ? 1'b1 : ~rx_en[ch],
               (md == M_TX) ? tx_d[ch] : 1'b1,
               (md == M_RX && rx_en[ch]) ? ro[ch] : 1'b1,
               1'b0};
        got = {de[ch], tx_ready[ch], busy[ch], ren[ch],
               di[ch], rx_d[ch], echo_err[ch]};
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL multi n %0d ch %0d got %b exp %b",
                   n, ch, got, exp);
        end
      end
    end
    tx_en = '0;
    rx_en = 3'b111;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic [3:0] got;
    logic [1:0] st;
    tx_en = '0;
    repeat (3) @(posedge clk);
    #1 tx_en[0] = 1'b1;
    repeat (8) @(posedge clk);
    #1 tx_d[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    got = {de[0], di[0], tx_ready[0], busy[0]};
    n_tests++;
    if (got !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_mid got %b exp 0100", got);
    end
    tx_en = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      st = {busy[0], de[0]};
      n_tests++;
      if (st !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d got %b exp 00", c, st);
      end
    end
    @(posedge clk);
    #1 tx_en[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st = {busy[0], de[0]};
    n_tests++;
    if (st !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_rearm got %b exp 11", st);
    end
    #1 tx_en[0] = 1'b0;
    repeat (15) @(posedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single_tx();
    test_resume();
    test_abort();
    test_echo();
    test_multi_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
